// File: rtl/dac_sample_pacer.sv
// Paces buffered 12-bit audio samples into the SPI DAC controller.
// One load/request per sample period; tracks underruns, missed ticks and timeouts.
module dac_sample_pacer #(
  parameter int          DIVIDE     = 2268,
  parameter int          FIFO_DEPTH = 16,
  parameter bit          SIGNED_IN  = 1'b1,
  parameter logic [11:0] MIDSCALE   = 12'h800,
  parameter int          TIMEOUT    = 256,
  localparam int         AW         = $clog2(FIFO_DEPTH),
  localparam int         LW         = $clog2(FIFO_DEPTH + 1),
  localparam int         CW         = $clog2(DIVIDE),
  localparam int         TW         = $clog2(TIMEOUT + 1)
) (
  input  logic          clock_50Mhz,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [11:0]   sample_in,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic [11:0]   dac_sample,
  output logic          dac_sendSample_n,
  input  logic          dac_isBusy,
  output logic [LW-1:0] fifo_level,
  output logic          underrun,
  output logic          tick_missed,
  output logic          timeout_err,
  output logic [15:0]   underrun_count
);

  typedef enum logic [1:0] {IDLE, LOAD, REQ, WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] div_q, div_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          busy_m_q, busy_s_q;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q;
  logic [11:0]   mem [FIFO_DEPTH];
  logic [11:0]   dac_q, dac_d, last_q, last_d;
  logic          send_n_q;
  logic          und_q, miss_q, tmo_err_q;
  logic [15:0]   und_cnt_q;

  logic          tick, push, pop, empty, is_load, tmo_fire;
  logic [11:0]   head, conv;

  // Sample period divider
  assign tick = enable && (div_q == CW'(DIVIDE - 1));

  always_comb begin
    div_d = div_q + 1'b1;
    if (!enable || tick) div_d = '0;
  end

  // FIFO
  assign empty = (level_q == '0);
  assign push  = sample_valid && ready_q;
  assign head  = mem[rptr_q];
  assign conv  = SIGNED_IN ? {~head[11], head[10:0]} : head;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock_50Mhz) begin
    if (push) mem[wptr_q] <= sample_in;
  end

  // Transfer FSM
  assign is_load = (state_q == LOAD);

  always_comb begin
    state_d  = state_q;
    tmo_d    = '0;
    pop      = 1'b0;
    tmo_fire = 1'b0;
    dac_d    = dac_q;
    last_d   = last_q;
    case (state_q)
      IDLE: if (tick) state_d = LOAD;
      LOAD: begin
        pop     = !empty;
        dac_d   = empty ? last_q : conv;
        last_d  = empty ? last_q : conv;
        state_d = REQ;
      end
      REQ: begin
        if (busy_s_q) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d  = IDLE;
          tmo_fire = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DONE: if (!busy_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      tmo_q     <= '0;
      busy_m_q  <= 1'b0;
      busy_s_q  <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      ready_q   <= 1'b1;
      dac_q     <= MIDSCALE;
      last_q    <= MIDSCALE;
      send_n_q  <= 1'b1;
      und_q     <= 1'b0;
      miss_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      und_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tmo_q     <= tmo_d;
      busy_m_q  <= dac_isBusy;
      busy_s_q  <= busy_m_q;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      level_q   <= level_d;
      ready_q   <= (level_d != LW'(FIFO_DEPTH));
      dac_q     <= dac_d;
      last_q    <= last_d;
      // Registered request so the line to the DAC controller never glitches
      send_n_q  <= (state_d != REQ);
      und_q     <= is_load && empty;
      miss_q    <= tick && (state_q != IDLE);
      tmo_err_q <= tmo_fire;
      if (is_load && empty && (und_cnt_q != 16'hFFFF)) und_cnt_q <= und_cnt_q + 1'b1;
    end
  end

  assign sample_ready     = ready_q;
  assign fifo_level       = level_q;
  assign dac_sample       = dac_q;
  assign dac_sendSample_n = send_n_q;
  assign underrun         = und_q;
  assign tick_missed      = miss_q;
  assign timeout_err      = tmo_err_q;
  assign underrun_count   = und_cnt_q;

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Directed bench for dac_sample_pacer with a behavioural DAC busy-flag model.
module tb_dac_sample_pacer;
  localparam int DIV = 2268;

  logic        gclk = 1'b0;
  logic        rst_n, enable, sample_valid, busy;
  logic [11:0] sample_in;
  logic        sample_ready, send_n, underrun, tick_missed, timeout_err;
  logic [11:0] dac_sample;
  logic [4:0]  fifo_level;
  logic [15:0] underrun_count;

  int n_chk = 0, n_pass = 0;
  int dac_mode = 0, busy_dly = 70, busy_hold = 20;

  dac_sample_pacer dut (
    .clock_50Mhz(gclk), .reset_n(rst_n), .enable(enable),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .dac_sample(dac_sample), .dac_sendSample_n(send_n), .dac_isBusy(busy),
    .fifo_level(fifo_level), .underrun(underrun), .tick_missed(tick_missed),
    .timeout_err(timeout_err), .underrun_count(underrun_count)
  );

  always #10 gclk = ~gclk;

  // Event monitor
  int cyc = 0;
  int req_cnt, und_cnt, miss_cnt, tmo_cnt, cur_low, last_low, req_cyc;
  logic prev_send;
  logic [11:0] req_sample;

  always @(posedge gclk) cyc <= cyc + 1;

  always @(negedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt <= 0; und_cnt <= 0; miss_cnt <= 0; tmo_cnt <= 0;
      cur_low <= 0; last_low <= 0; req_cyc <= 0; prev_send <= 1'b1; req_sample <= '0;
    end else begin
      prev_send <= send_n;
      if (prev_send && !send_n) begin
        req_cnt    <= req_cnt + 1;
        req_cyc    <= cyc;
        req_sample <= dac_sample;
      end
      if (underrun)    und_cnt  <= und_cnt + 1;
      if (tick_missed) miss_cnt <= miss_cnt + 1;
      if (timeout_err) tmo_cnt  <= tmo_cnt + 1;
      if (!send_n) cur_low <= cur_low + 1;
      else if (cur_low != 0) begin last_low <= cur_low; cur_low <= 0; end
    end
  end

  // DAC controller model: raise busy busy_dly cycles after a request, hold busy_hold
  initial begin
    int dst, dcnt;
    busy = 1'b0; dst = 0; dcnt = 0;
    forever begin
      @(negedge gclk);
      if (!rst_n) begin busy = 1'b0; dst = 0; end
      else case (dst)
        0: if (dac_mode != 0 && send_n === 1'b0) begin dst = 1; dcnt = 1; end
        1: if (dcnt >= busy_dly) begin busy = 1'b1; dst = 2; dcnt = 1; end else dcnt++;
        default: if (dcnt >= busy_hold) begin busy = 1'b0; dst = 0; end else dcnt++;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_in = '0;
    repeat (3) @(negedge gclk);
    rst_n = 1'b1;
    @(negedge gclk);
  endtask

  task automatic push(input logic [11:0] v);
    sample_valid = 1'b1; sample_in = v;
    @(negedge gclk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int budget);
    int start = req_cnt;
    int i = 0;
    while (req_cnt == start && i < budget) begin @(negedge gclk); i++; end
    chk({tag, "_req_seen"}, 32'(req_cnt != start), 32'd1);
  endtask

  initial begin
    int t0, t1, acc;
    logic rdy17;
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_in = '0;
    repeat (2) @(negedge gclk);
    chk("rst_send_n", 32'(send_n), 32'd1);
    chk("rst_dac", 32'(dac_sample), 32'h800);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ready", 32'(sample_ready), 32'd1);
    chk("rst_ucount", 32'(underrun_count), 32'd0);
    chk("rst_pulses", 32'({underrun, tick_missed, timeout_err}), 32'd0);

    // 1: three samples, one request per tick
    do_reset();
    dac_mode = 1; busy_dly = 70; busy_hold = 20;
    push(12'h000); push(12'h7FF); push(12'h800);
    chk("t1_level3", 32'(fifo_level), 32'd3);
    enable = 1'b1;
    wait_req("t1a", DIV + 50);
    chk("t1_s0", 32'(req_sample), 32'h800);
    t0 = req_cyc;
    wait_req("t1b", DIV + 50);
    chk("t1_s1", 32'(req_sample), 32'hFFF);
    chk("t1_gap1", 32'(req_cyc - t0), 32'(DIV));
    t1 = req_cyc;
    wait_req("t1c", DIV + 50);
    chk("t1_s2", 32'(req_sample), 32'h000);
    chk("t1_gap2", 32'(req_cyc - t1), 32'(DIV));
    repeat (200) @(negedge gclk);
    chk("t1_level0", 32'(fifo_level), 32'd0);
    chk("t1_reqs", 32'(req_cnt), 32'd3);
    chk("t1_no_und", 32'(und_cnt), 32'd0);

    // 2: underrun repeats last sample
    do_reset();
    enable = 1'b1;
    wait_req("t2a", DIV + 50);
    chk("t2_mid", 32'(req_sample), 32'h800);
    repeat (5) @(negedge gclk);
    chk("t2_und1", 32'(und_cnt), 32'd1);
    chk("t2_ucnt1", 32'(underrun_count), 32'd1);
    push(12'h123);
    wait_req("t2b", DIV + 50);
    chk("t2_conv", 32'(req_sample), 32'h923);
    wait_req("t2c", DIV + 50);
    chk("t2_repeat", 32'(req_sample), 32'h923);
    repeat (5) @(negedge gclk);
    chk("t2_ucnt2", 32'(underrun_count), 32'd2);

    // 3: overfill a 16-deep FIFO
    do_reset();
    acc = 0; rdy17 = 1'b1;
    sample_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample_in = 12'(i);
      if (i == 16) rdy17 = sample_ready;
      if (sample_ready) acc++;
      @(negedge gclk);
    end
    sample_valid = 1'b0;
    chk("t3_accepted", 32'(acc), 32'd16);
    chk("t3_ready_full", 32'(rdy17), 32'd0);
    chk("t3_level16", 32'(fifo_level), 32'd16);
    enable = 1'b1;
    wait_req("t3a", DIV + 50);
    chk("t3_s0", 32'(req_sample), 32'h800);
    chk("t3_level15", 32'(fifo_level), 32'd15);
    chk("t3_ready_again", 32'(sample_ready), 32'd1);
    push(12'h555);
    chk("t3_refill", 32'(fifo_level), 32'd16);
    wait_req("t3b", DIV + 50);
    chk("t3_s1", 32'(req_sample), 32'h801);

    // 4: busy never asserted
    do_reset();
    dac_mode = 0;
    enable = 1'b1;
    wait_req("t4a", DIV + 50);
    t0 = req_cyc;
    for (int i = 0; i < 400 && send_n == 1'b0; i++) @(negedge gclk);
    repeat (3) @(negedge gclk);
    chk("t4_low_len", 32'(last_low), 32'd256);
    chk("t4_tmo", 32'(tmo_cnt), 32'd1);
    wait_req("t4b", DIV + 50);
    chk("t4_gap", 32'(req_cyc - t0), 32'(DIV));
    chk("t4_no_miss", 32'(miss_cnt), 32'd0);

    // 5: busy longer than a period
    do_reset();
    dac_mode = 1; busy_dly = 70; busy_hold = 3000;
    enable = 1'b1;
    wait_req("t5a", DIV + 50);
    t0 = req_cyc;
    repeat (2300) @(negedge gclk);
    chk("t5_miss", 32'(miss_cnt), 32'd1);
    chk("t5_one_req", 32'(req_cnt), 32'd1);
    wait_req("t5b", DIV + 100);
    chk("t5_gap", 32'(req_cyc - t0), 32'(2 * DIV));
    chk("t5_miss_still1", 32'(miss_cnt), 32'd1);

    // 6: reset mid-request
    do_reset();
    dac_mode = 0;
    enable = 1'b1;
    wait_req("t6a", DIV + 50);
    push(12'h321);
    repeat (5) @(negedge gclk);
    chk("t6_in_req", 32'(send_n), 32'd0);
    chk("t6_ucnt_pre", 32'(underrun_count), 32'd1);
    chk("t6_level_pre", 32'(fifo_level), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_send_n", 32'(send_n), 32'd1);
    chk("t6_dac", 32'(dac_sample), 32'h800);
    chk("t6_level", 32'(fifo_level), 32'd0);
    chk("t6_ucnt", 32'(underrun_count), 32'd0);
    chk("t6_ready", 32'(sample_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dac_sample_pacer.md
Name: dac_sample_pacer

Overview:
- Sits directly upstream of the SPI DAC output controller and feeds it one 12-bit sample per audio period (22050 Hz).
- Buffers samples from the synth/mixer in a small FIFO (valid/ready).
- Generates the active-low send request and tracks the controller's busy flag so that exactly one transfer starts per period.
- Detects and counts underruns, missed periods and handshake timeouts.

Parameters:
- DIVIDE, 2268: 50 MHz clock cycles per sample period (50e6/22050, rounded).
- FIFO_DEPTH, 16: sample FIFO entries, power of two, ≥2.
- SIGNED_IN, 1: 1 = input is two's complement; convert to offset binary by inverting bit 11. 0 = pass the input through unchanged.
- MIDSCALE, 12'h800: value of last_sample after reset.
- TIMEOUT, 256: maximum cycles in REQ before aborting.

Ports:
- clock_50Mhz  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  1 = pacing active; 0 = divider held at 0 and no ticks
- sample_in  in  12  upstream sample
- sample_valid  in  1  sample_in is valid
- sample_ready  out  1  FIFO can accept a sample (= !full)
- dac_sample  out  12  sample presented to the DAC controller
- dac_sendSample_n  out  1  active-low transfer request
- dac_isBusy  in  1  controller busy flag (slow-clock domain)
- fifo_level  out  5  current FIFO occupancy, 0..FIFO_DEPTH
- underrun  out  1  1-cycle pulse: FIFO empty at LOAD
- tick_missed  out  1  1-cycle pulse: tick arrived while not in IDLE
- timeout_err  out  1  1-cycle pulse: REQ aborted
- underrun_count  out  16  saturating count of underrun pulses

Behaviour:
- Reset values (async, immediate):
  - FSM = IDLE, divider = 0, FIFO empty, fifo_level = 0, sample_ready = 1.
  - dac_sendSample_n = 1, dac_sample = MIDSCALE, last_sample = MIDSCALE.
  - All pulse outputs = 0, underrun_count = 0, busy synchroniser flops = 0.
  - Reset mid-transfer abandons the transfer; the request line goes high immediately.
- Divider:
  - Counts 0..DIVIDE-1 while enable = 1.
  - tick is a 1-cycle internal pulse when count = DIVIDE-1; the count then wraps to 0.
  - Dropping enable clears the count in the next cycle.
- FIFO:
  - Push when sample_valid && sample_ready.
  - Pop only in LOAD.
  - Push and pop in the same cycle: level unchanged, both honoured.
  - When full, sample_ready = 0 and data is not written, even if a pop occurs in the same cycle. sample_ready is registered from the level.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- dac_isBusy passes through a 2-flop synchroniser to busy_s before any use.
- FSM:
  - IDLE: on tick go to LOAD.
  - LOAD (1 cycle):
    - FIFO non-empty: pop; dac_sample and last_sample take the converted sample.
    - FIFO empty: dac_sample = last_sample and underrun pulses.
    - Then go to REQ.
  - REQ:
    - dac_sendSample_n = 0; dac_sample held stable.
    - When busy_s = 1, set dac_sendSample_n = 1 and go to WAIT_DONE.
    - If TIMEOUT cycles pass without busy_s, set dac_sendSample_n = 1, pulse timeout_err and go to IDLE.
  - WAIT_DONE: when busy_s = 0, go to IDLE. dac_sample stays held.
- Latency: tick in cycle t gives LOAD in t+1 and dac_sendSample_n = 0 in t+2. dac_sample is valid no later than that cycle.
- A tick in any state other than IDLE pulses tick_missed and is discarded; it is not queued.
- enable = 0 during a transfer: the current transfer completes normally; no further ticks.
- Conversion: with SIGNED_IN = 1, out = {~in[11], in[10:0]}, e.g. 12'h000 → 12'h800 and 12'hFFF (−1) → 12'h7FF.
- underrun_count saturates at 16'hFFFF.

Test Plan:
1. Reset, push 3 samples (12'h000, 12'h7FF, 12'h800; SIGNED_IN = 1), DAC model asserts busy 70 cycles after the request → dac_sample = 800, FFF, 000 on successive ticks, 2268 cycles apart; one request per tick; fifo_level returns to 0.
2. FIFO empty at tick after reset → dac_sample = 800, underrun pulses once, underrun_count = 1; next sample 12'h123 pushed then sent as 12'h923; the following empty tick repeats 12'h923.
3. Push 20 samples back-to-back with DEPTH = 16 → sample_ready low after the 16th push; samples 17–20 not written; the tick-driven pop re-raises sample_ready and the next valid push succeeds.
4. DAC model never asserts busy → dac_sendSample_n low for exactly 256 cycles, then high; timeout_err pulses; FSM back in IDLE before the next tick.
5. DAC model holds busy for 3000 cycles → tick_missed pulses at the next tick, no second request until busy falls, then normal operation at the following tick.
6. Assert reset_n low mid-REQ → dac_sendSample_n = 1 and dac_sample = 800 immediately; FIFO empty; counters cleared.
